seq_pattern_detector: RTL and testbench

Parametrised serial pattern detector that generalises the fixed-pattern Moore detector. It takes one bit per valid cycle and compares the most recent bits against a runtime-programmable pattern of 1..MAX_LEN bits. Overlapping or non-overlapping match mode is selectable, and an optional saturating match counter is available. It sits on the serial input path, and its one-cycle match pulse drives downstream framing/alignment logic.

---
 rtl/seq_pattern_detector.sv | 133 +++++++++++++
 tb/tb_seq_pattern_detector.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_detector.sv
// Serial detector for a runtime-loaded 1..MAX_LEN bit pattern, with an optional saturating match counter (MATCH_COUNT_EN).
// Match pulse one cycle after the completing bit; accepts one bit per cycle, never back-pressures.
module seq_pattern_detector #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Binary_In,
  input  logic               In_Valid,
  input  logic               Cfg_Load,
  input  logic [MAX_LEN-1:0] Cfg_Pattern,
  input  logic [LEN_W-1:0]   Cfg_Len,
  input  logic               Cfg_Overlap,
  output logic               sequence_detected,
  output logic               Armed,
  output logic               Cfg_Err,
  output logic [CNT_W-1:0]   Match_Count
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               ovl_q, ovl_d;
  logic               det_q, det_d;
  logic               err_q, err_d;

  logic [MAX_LEN-1:0] len_mask;
  logic [MAX_LEN-1:0] hist_shift;
  logic [LEN_W-1:0]   fill_inc;
  logic               cfg_legal;
  logic               hit;

`ifdef MATCH_COUNT_EN
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

  // Only the low len_q history bits take part in the compare.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
  end

  assign cfg_legal  = (Cfg_Len != '0) && (Cfg_Len <= LEN_W'(MAX_LEN));
  assign hist_shift = {hist_q[MAX_LEN-2:0], Binary_In};
  assign fill_inc   = (fill_q < len_q) ? fill_q + 1'b1 : len_q;
  assign hit        = (fill_inc == len_q) && (((hist_shift ^ pat_q) & len_mask) == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      hist_q  <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      ovl_q   <= 1'b0;
      det_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef MATCH_COUNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      ovl_q   <= ovl_d;
      det_q   <= det_d;
      err_q   <= err_d;
`ifdef MATCH_COUNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    pat_d   = pat_q;
    len_d   = len_q;
    fill_d  = fill_q;
    ovl_d   = ovl_q;
    det_d   = 1'b0;
    err_d   = 1'b0;
`ifdef MATCH_COUNT_EN
    cnt_d   = cnt_q;
`endif
    // A load always takes priority; any bit presented alongside it is dropped.
    if (Cfg_Load) begin
      if (cfg_legal) begin
        state_d = RUN;
        pat_d   = Cfg_Pattern;
        len_d   = Cfg_Len;
        ovl_d   = Cfg_Overlap;
        hist_d  = '0;
        fill_d  = '0;
`ifdef MATCH_COUNT_EN
        cnt_d   = '0;
`endif
      end else begin
        err_d = 1'b1;
      end
    end else if (state_q == RUN && In_Valid) begin
      hist_d = hist_shift;
      fill_d = fill_inc;
      if (hit) begin
        det_d = 1'b1;
        if (!ovl_q) fill_d = '0;
`ifdef MATCH_COUNT_EN
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
`endif
      end
    end
  end

  assign sequence_detected = det_q;
  assign Armed             = (state_q == RUN);
  assign Cfg_Err           = err_q;
`ifdef MATCH_COUNT_EN
  assign Match_Count       = cnt_q;
`else
  assign Match_Count       = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: directed vector table, counter sequence, then randomized traffic against a bit-queue model.
module tb_seq_pattern_detector;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 2;

  logic               CLK;
  logic               RST;
  logic               Binary_In;
  logic               In_Valid;
  logic               Cfg_Load;
  logic [MAX_LEN-1:0] Cfg_Pattern;
  logic [LEN_W-1:0]   Cfg_Len;
  logic               Cfg_Overlap;
  logic               sequence_detected;
  logic               Armed;
  logic               Cfg_Err;
  logic [CNT_W-1:0]   Match_Count;

  seq_pattern_detector #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .Binary_In(Binary_In), .In_Valid(In_Valid),
    .Cfg_Load(Cfg_Load), .Cfg_Pattern(Cfg_Pattern), .Cfg_Len(Cfg_Len),
    .Cfg_Overlap(Cfg_Overlap), .sequence_detected(sequence_detected),
    .Armed(Armed), .Cfg_Err(Cfg_Err), .Match_Count(Match_Count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst, load;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl, vld, bin;
    logic       e_det, e_arm, e_err;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: accepted bits since the last load/clear, oldest first.
  bit         m_armed;
  bit [7:0]   m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_bits[$];
  bit         m_det, m_err;
  int         m_cnt;

  function automatic vec_t mk(logic rst, logic load, logic [7:0] pat, logic [3:0] len,
                              logic ovl, logic vld, logic bin,
                              logic e_det, logic e_arm, logic e_err);
    vec_t v;
    v.rst = rst; v.load = load; v.pat = pat; v.len = len; v.ovl = ovl;
    v.vld = vld; v.bin = bin; v.e_det = e_det; v.e_arm = e_arm; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(vec_t v);
    bit match;
    int n;
    m_det = 1'b0;
    m_err = 1'b0;
    if (v.rst) begin
      m_armed = 1'b0; m_pat = '0; m_len = 0; m_ovl = 1'b0;
      m_bits.delete(); m_cnt = 0;
    end else if (v.load) begin
      if (v.len >= 1 && v.len <= MAX_LEN) begin
        m_armed = 1'b1; m_pat = v.pat; m_len = int'(v.len); m_ovl = v.ovl;
        m_bits.delete(); m_cnt = 0;
      end else begin
        m_err = 1'b1;
      end
    end else if (m_armed && v.vld) begin
      m_bits.push_back(v.bin);
      if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
      n = m_bits.size();
      if (n >= m_len) begin
        match = 1'b1;
        for (int i = 0; i < m_len; i++)
          if (m_bits[n - m_len + i] != m_pat[m_len - 1 - i]) match = 1'b0;
        if (match) begin
          m_det = 1'b1;
          if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
          if (!m_ovl) m_bits.delete();
        end
      end
    end
  endtask

  task automatic apply(vec_t v, string tag);
    int exp_cnt;
    RST = v.rst; Cfg_Load = v.load; Cfg_Pattern = v.pat; Cfg_Len = v.len;
    Cfg_Overlap = v.ovl; In_Valid = v.vld; Binary_In = v.bin;
    model_step(v);
    @(posedge CLK);
    #1;
`ifdef MATCH_COUNT_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 0;
`endif
    check({tag, " model det"}, int'(sequence_detected), int'(m_det));
    check({tag, " model armed"}, int'(Armed), int'(m_armed));
    check({tag, " model err"}, int'(Cfg_Err), int'(m_err));
    check({tag, " model count"}, int'(Match_Count), exp_cnt);
  endtask

  initial begin
    vec_t v;
    int   cnt_exp[5];
    RST = 1'b0; Cfg_Load = 1'b0; Cfg_Pattern = '0; Cfg_Len = '0;
    Cfg_Overlap = 1'b0; In_Valid = 1'b0; Binary_In = 1'b0;

    // rst load pat len ovl vld bin | det arm err
    vecs.push_back(mk(1,0,8'h00,4'd0,0,0,0, 0,0,0));
    // 011 non-overlap: pulses after bits 4 and 7
    vecs.push_back(mk(0,1,8'b011,4'd3,0,0,0, 0,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,0,1,0, 0,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,0,1,0, 0,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,0,1,1, 0,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,0,1,1, 1,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,0,1,0, 0,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,0,1,1, 0,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,0,1,1, 1,1,0));
    // 101 overlap: pulses after bits 3 and 5
    vecs.push_back(mk(0,1,8'b101,4'd3,1,0,0, 0,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,0,1,1, 0,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,0,1,0, 0,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,0,1,1, 1,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,0,1,0, 0,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,0,1,1, 1,1,0));
    // 101 non-overlap: single pulse
    vecs.push_back(mk(0,1,8'b101,4'd3,0,0,0, 0,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,1,1,1, 0,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,1,1,0, 0,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,1,1,1, 1,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,1,1,0, 0,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,1,1,1, 0,1,0));
    // 1101 with gapped valid
    vecs.push_back(mk(0,1,8'b1101,4'd4,0,0,0, 0,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,0,1,1, 0,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,0,0,0, 0,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,0,1,1, 0,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,0,0,1, 0,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,0,1,0, 0,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,0,0,1, 0,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,0,1,1, 1,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,0,0,1, 0,1,0));
    // illegal loads from IDLE, then a legal one
    vecs.push_back(mk(1,0,8'h00,4'd0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,1,8'b1,4'd0,0,0,0, 0,0,1));
    vecs.push_back(mk(0,1,8'b1,4'd9,0,0,0, 0,0,1));
    vecs.push_back(mk(0,0,8'h00,4'd0,0,1,1, 0,0,0));
    vecs.push_back(mk(0,1,8'b011,4'd3,0,0,0, 0,1,0));
    // illegal load while running keeps config and history
    vecs.push_back(mk(0,0,8'h00,4'd0,0,1,0, 0,1,0));
    vecs.push_back(mk(0,1,8'hFF,4'd0,1,0,0, 0,1,1));
    vecs.push_back(mk(0,0,8'h00,4'd0,0,1,1, 0,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,0,1,1, 1,1,0));
    // reset mid-pattern, reload with a discarded bit, then last bit alone and full sequence
    vecs.push_back(mk(0,0,8'h00,4'd0,0,1,0, 0,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,0,1,1, 0,1,0));
    vecs.push_back(mk(1,0,8'h00,4'd0,0,1,1, 0,0,0));
    vecs.push_back(mk(0,1,8'b011,4'd3,0,1,0, 0,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,0,1,1, 0,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,0,1,0, 0,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,0,1,1, 0,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,0,1,1, 1,1,0));
    // length 1, upper pattern bits ignored
    vecs.push_back(mk(0,1,8'hFE,4'd1,1,0,0, 0,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,0,1,0, 1,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,0,1,1, 0,1,0));
    vecs.push_back(mk(0,0,8'h00,4'd0,0,1,0, 1,1,0));

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      apply(vecs[i], tag);
      check({tag, " det"}, int'(sequence_detected), int'(vecs[i].e_det));
      check({tag, " armed"}, int'(Armed), int'(vecs[i].e_arm));
      check({tag, " err"}, int'(Cfg_Err), int'(vecs[i].e_err));
    end

    // Saturating counter: pattern 1, length 1, five ones
    cnt_exp = '{1, 2, 3, 3, 3};
    apply(mk(0,1,8'b1,4'd1,0,0,0, 0,0,0), "cnt load");
    check("cnt after load", int'(Match_Count), 0);
    for (int i = 0; i < 5; i++) begin
      apply(mk(0,0,8'h00,4'd0,0,1,1, 0,0,0), $sformatf("cnt%0d", i));
`ifdef MATCH_COUNT_EN
      check($sformatf("count%0d", i), int'(Match_Count), cnt_exp[i]);
`else
      check($sformatf("count%0d", i), int'(Match_Count), 0);
`endif
    end

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      v.rst  = ($urandom_range(0, 299) == 0);
      v.load = ($urandom_range(0, 24) == 0);
      v.pat  = 8'($urandom);
      v.len  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(1, 4));
      v.ovl  = 1'($urandom);
      v.vld  = ($urandom_range(0, 3) != 0);
      v.bin  = 1'($urandom);
      v.e_det = 1'b0; v.e_arm = 1'b0; v.e_err = 1'b0;
      apply(v, $sformatf("rnd%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
